// File: rtl/injector_local_port_if.sv
// Req/Gnt/Full handshake between a packet source and a router Local input port.
// The master drives the request and packet word; the slave returns grant and full.
interface injector_local_port_if #(
  parameter int dataWidth = 32
);
  logic                 ReqDnStr;
  logic                 GntDnStr;
  logic                 DnStrFull;
  logic [dataWidth-1:0] PacketOut;

  modport master (output ReqDnStr, PacketOut, input GntDnStr, DnStrFull);
  modport slave  (input ReqDnStr, PacketOut, output GntDnStr, DnStrFull);
endinterface

// File: rtl/injector_local_port.sv
// Per-PE packet source for the mesh. It sends PacketCount packets to DestID and
// leaves InjectGap idle cycles after each grant before it raises the next request.
module injector_local_port #(
  parameter logic [5:0] routerID    = 6'b000_000,
  parameter logic [5:0] ModuleID    = 6'b000_000,
  parameter logic [5:0] DestID      = 6'b000_000,
  parameter int         dataWidth   = 32,
  parameter int         dim         = 4,
  parameter int         PacketCount = 16,
  parameter int         InjectGap   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Enable,
  injector_local_port_if.master        lp,
  output logic [15:0]                  SentCount,
  output logic [31:0]                  LastInjectCycle,
  output logic                         Done
);
  localparam int IDW = (dim - 1) * 2;
  localparam int GW  = (InjectGap < 2) ? 1 : $clog2(InjectGap + 1);
  localparam logic [15:0] PC = 16'(PacketCount);

  if (dataWidth < 22 || IDW != 6 || routerID >= (1 << IDW))
    $error("injector_local_port: unsupported dataWidth/dim/routerID");

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  state_t          state;
  logic [9:0]      pkt_id;
  logic [31:0]     cycle_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [21:0]     pkt_word;

  assign pkt_word = {DestID, pkt_id, ModuleID};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      pkt_id          <= '0;
      cycle_cnt       <= '0;
      gap_cnt         <= '0;
      lp.ReqDnStr     <= 1'b0;
      lp.PacketOut    <= '0;
      SentCount       <= '0;
      LastInjectCycle <= '0;
      Done            <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      case (state)
        IDLE: if (Enable && !lp.DnStrFull) begin
          lp.PacketOut <= dataWidth'(pkt_word);
          lp.ReqDnStr  <= 1'b1;
          state        <= REQ;
        end
        // Once raised, the request stays up until granted regardless of Enable/Full.
        REQ: if (lp.GntDnStr) begin
          lp.ReqDnStr     <= 1'b0;
          pkt_id          <= pkt_id + 10'd1;
          SentCount       <= SentCount + 16'd1;
          LastInjectCycle <= cycle_cnt;
          if (PacketCount != 0 && 16'(SentCount + 16'd1) == PC) begin
            state <= DONE;
            Done  <= 1'b1;
          end else if (InjectGap == 0) begin
            state <= IDLE;
          end else begin
            state   <= GAP;
            gap_cnt <= GW'(InjectGap);
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - GW'(1);
          if (gap_cnt == GW'(1)) state <= IDLE;
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_injector_local_port.sv
// Directed bench: three injector instances cover the default config, zero gap,
// and unlimited count with packet-ID wrap.
module tb_injector_local_port;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic [15:0] sent_a, sent_b, sent_c;
  logic [31:0] last_a, last_b, last_c;
  logic done_a, done_b, done_c;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  injector_local_port_if #(.dataWidth(32)) a_if ();
  injector_local_port_if #(.dataWidth(32)) b_if ();
  injector_local_port_if #(.dataWidth(32)) c_if ();

  injector_local_port #(.ModuleID(6'b001_010), .DestID(6'b011_010)) u_a (
    .clk(clk), .reset(reset), .Enable(en_a), .lp(a_if.master),
    .SentCount(sent_a), .LastInjectCycle(last_a), .Done(done_a));

  injector_local_port #(.ModuleID(6'd1), .DestID(6'd2), .InjectGap(0)) u_b (
    .clk(clk), .reset(reset), .Enable(en_b), .lp(b_if.master),
    .SentCount(sent_b), .LastInjectCycle(last_b), .Done(done_b));

  injector_local_port #(.ModuleID(6'd3), .DestID(6'd5), .PacketCount(0), .InjectGap(0)) u_c (
    .clk(clk), .reset(reset), .Enable(en_c), .lp(c_if.master),
    .SentCount(sent_c), .LastInjectCycle(last_c), .Done(done_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    en_a = 0; en_b = 0; en_c = 0;
    a_if.GntDnStr = 0; a_if.DnStrFull = 0;
    b_if.GntDnStr = 0; b_if.DnStrFull = 0;
    c_if.GntDnStr = 0; c_if.DnStrFull = 0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic wait_req_a();
    int n = 0;
    while (!a_if.ReqDnStr && n < 20) begin tick(); n++; end
    checks++;
    if (a_if.ReqDnStr !== 1'b1) begin
      errors++;
      $display("FAIL wait_req_a: req=%b after %0d cycles, required 1", a_if.ReqDnStr, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_if.ReqDnStr, a_if.PacketOut, sent_a, last_a, done_a} !== '0) begin
      errors++;
      $display("FAIL reset_state: req=%b pkt=%h sent=%0d last=%0d done=%b, required all 0",
               a_if.ReqDnStr, a_if.PacketOut, sent_a, last_a, done_a);
    end
  endtask

  task automatic test_basic_send();
    logic [31:0] exp, prev_last;
    do_reset();
    en_a = 1;
    prev_last = '0;
    for (int k = 0; k < 16; k++) begin
      wait_req_a();
      exp = 32'h001A_000A | (32'(k) << 6);
      checks++;
      if (a_if.PacketOut !== exp) begin
        errors++;
        $display("FAIL basic_pkt[%0d]: got %h, required %h", k, a_if.PacketOut, exp);
      end
      a_if.GntDnStr = 1; tick(); a_if.GntDnStr = 0;
      checks++;
      if (sent_a !== 16'(k + 1) || a_if.ReqDnStr !== 1'b0) begin
        errors++;
        $display("FAIL basic_grant[%0d]: sent=%0d req=%b, required sent=%0d req=0",
                 k, sent_a, a_if.ReqDnStr, k + 1);
      end
      if (k > 0) begin
        checks++;
        if (last_a - prev_last !== 32'd4) begin
          errors++;
          $display("FAIL basic_last_spacing[%0d]: got %0d, required 4", k, last_a - prev_last);
        end
      end
      prev_last = last_a;
    end
    // Done is sticky and further grants are ignored.
    a_if.GntDnStr = 1;
    for (int i = 0; i < 4; i++) tick();
    a_if.GntDnStr = 0;
    checks++;
    if (done_a !== 1'b1 || sent_a !== 16'd16 || a_if.ReqDnStr !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b sent=%0d req=%b, required 1/16/0",
               done_a, sent_a, a_if.ReqDnStr);
    end
  endtask

  task automatic test_gap_timing();
    logic [3:0] seen;
    int n;
    do_reset();
    en_a = 1;
    wait_req_a();
    a_if.GntDnStr = 1; tick(); a_if.GntDnStr = 0;
    seen[0] = a_if.ReqDnStr;
    tick(); seen[1] = a_if.ReqDnStr;
    tick(); seen[2] = a_if.ReqDnStr;
    tick(); seen[3] = a_if.ReqDnStr;
    checks++;
    if (seen !== 4'b1000) begin
      errors++;
      $display("FAIL gap2_req: req at t..t+3 = %b (t+3..t), required 1000", seen);
    end
    en_b = 1;
    n = 0;
    while (!b_if.ReqDnStr && n < 20) begin tick(); n++; end
    b_if.GntDnStr = 1; tick(); b_if.GntDnStr = 0;
    seen[0] = b_if.ReqDnStr;
    tick(); seen[1] = b_if.ReqDnStr;
    checks++;
    if (seen[1:0] !== 2'b10) begin
      errors++;
      $display("FAIL gap0_req: req at t,t+1 = %b (t+1,t), required 10", seen[1:0]);
    end
  endtask

  task automatic test_backpressure();
    int low_bad = 0;
    logic [31:0] held;
    do_reset();
    a_if.DnStrFull = 1; en_a = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_if.ReqDnStr !== 1'b0) low_bad++;
    end
    checks++;
    if (low_bad != 0) begin
      errors++;
      $display("FAIL bp_idle: req high in %0d of 10 full cycles, required 0", low_bad);
    end
    a_if.DnStrFull = 0; tick();
    checks++;
    if (a_if.ReqDnStr !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: req=%b one cycle after full fell, required 1", a_if.ReqDnStr);
    end
    held = a_if.PacketOut;
    a_if.DnStrFull = 1; en_a = 0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (a_if.ReqDnStr !== 1'b1 || a_if.PacketOut !== 32'h001A_000A || held !== 32'h001A_000A) begin
      errors++;
      $display("FAIL bp_hold: req=%b pkt=%h, required 1 and 001a000a", a_if.ReqDnStr, a_if.PacketOut);
    end
    a_if.GntDnStr = 1; tick(); a_if.GntDnStr = 0; a_if.DnStrFull = 0;
    checks++;
    if (sent_a !== 16'd1 || a_if.ReqDnStr !== 1'b0) begin
      errors++;
      $display("FAIL bp_grant: sent=%0d req=%b, required 1 and 0", sent_a, a_if.ReqDnStr);
    end
  endtask

  task automatic test_stuck_grant();
    logic [15:0] got [5];
    do_reset();
    a_if.GntDnStr = 1; en_a = 1;
    for (int i = 0; i < 5; i++) begin tick(); got[i] = sent_a; end
    a_if.GntDnStr = 0;
    checks++;
    if (got[0] !== 16'd0 || got[1] !== 16'd1 || got[2] !== 16'd1 || got[3] !== 16'd1 || got[4] !== 16'd1) begin
      errors++;
      $display("FAIL stuck_count: sent per cycle %0d %0d %0d %0d %0d, required 0 1 1 1 1",
               got[0], got[1], got[2], got[3], got[4]);
    end
    checks++;
    if (a_if.ReqDnStr !== 1'b1 || a_if.PacketOut !== 32'h001A_004A) begin
      errors++;
      $display("FAIL stuck_next_req: req=%b pkt=%h, required 1 and 001a004a", a_if.ReqDnStr, a_if.PacketOut);
    end
    a_if.GntDnStr = 1; tick(); a_if.GntDnStr = 0;
    checks++;
    if (sent_a !== 16'd2) begin
      errors++;
      $display("FAIL stuck_second: sent=%0d, required 2", sent_a);
    end
  endtask

  task automatic test_wrap_unlimited();
    int n;
    do_reset();
    en_c = 1;
    for (int k = 0; k < 1100; k++) begin
      n = 0;
      while (!c_if.ReqDnStr && n < 20) begin tick(); n++; end
      if (k == 0) begin
        checks++;
        if (c_if.PacketOut !== 32'h0005_0003) begin
          errors++;
          $display("FAIL wrap_first_pkt: got %h, required 00050003", c_if.PacketOut);
        end
      end
      checks++;
      if (c_if.ReqDnStr !== 1'b1 || c_if.PacketOut[15:6] !== 10'(k % 1024)) begin
        errors++;
        $display("FAIL wrap_id[%0d]: req=%b id=%0d, required 1 and %0d",
                 k, c_if.ReqDnStr, c_if.PacketOut[15:6], k % 1024);
      end
      c_if.GntDnStr = 1; tick(); c_if.GntDnStr = 0;
    end
    checks++;
    if (sent_c !== 16'd1100 || done_c !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: sent=%0d done=%b, required 1100 and 0", sent_c, done_c);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en_a = 1;
    wait_req_a();
    a_if.GntDnStr = 1; tick(); a_if.GntDnStr = 0;
    wait_req_a();
    #3 reset = 1'b0;
    #1;
    checks++;
    if (a_if.ReqDnStr !== 1'b0 || sent_a !== 16'd0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: req=%b sent=%0d done=%b, required 0/0/0",
               a_if.ReqDnStr, sent_a, done_a);
    end
    tick();
    reset = 1'b1;
    wait_req_a();
    checks++;
    if (a_if.PacketOut !== 32'h001A_000A || sent_a !== 16'd0) begin
      errors++;
      $display("FAIL async_restart: pkt=%h sent=%0d, required 001a000a and 0", a_if.PacketOut, sent_a);
    end
  endtask

  initial begin
    test_reset();
    test_basic_send();
    test_gap_timing();
    test_backpressure();
    test_stuck_grant();
    test_wrap_unlimited();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
